alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Initiator side of the tensor-core ALU interface. It accepts one vector command at a time through a valid/ready handshake and reads operand pairs from the operand register file. For each element it drives the ALU's enable/opcode/operand inputs, captures the registered ALU result one cycle later, and writes it back to the register file. It sits between the core's instruction decode and the alu instance, and is the only driver of the ALU's inputs.

Parameters:
DATA_W, 8, operand/result width (signed two's complement); must match ALU width
ADDR_W, 4, register-file address width; addresses wrap modulo 2**ADDR_W
LEN_W, 5, command length field width; element count 0..2**LEN_W-1

Ports:
clock_in  input  1  single clock, rising edge
reset_in  input  1  asynchronous, active-high reset
cmd_valid_in  input  1  command present
cmd_ready_out  output  1  sequencer can accept a command
cmd_opcode_in  input  3  0 ADD, 1 SUBTRACT, 2 MULTIPLY, 3 EQUALS, 4 GREATER_THAN
cmd_src_a_in  input  ADDR_W  base address of operand vector A
cmd_src_b_in  input  ADDR_W  base address of operand vector B
cmd_dst_in  input  ADDR_W  base address of result vector
cmd_len_in  input  LEN_W  element count
rd_en_out  output  1  register-file read strobe (synchronous read, data next cycle)
rd_addr_a_out  output  ADDR_W  read address A
rd_addr_b_out  output  ADDR_W  read address B
rd_data_a_in  input  DATA_W  read data A
rd_data_b_in  input  DATA_W  read data B
alu_enable_out  output  1  to ALU enable_in
alu_opcode_out  output  3  to ALU opcode_in
alu_input1_out  output  DATA_W  to ALU alu_input1 (from rd_data_a_in)
alu_input2_out  output  DATA_W  to ALU alu_input2 (from rd_data_b_in)
alu_result_in  input  DATA_W  from ALU alu_output
wr_en_out  output  1  register-file write strobe
wr_addr_out  output  ADDR_W  write address
wr_data_out  output  DATA_W  write data (= alu_result_in)
busy_out  output  1  command in flight
done_out  output  1  one-cycle completion pulse
err_out  output  1  one-cycle pulse, coincident with done_out, for an illegal opcode

Behaviour:
- Reset: asynchronous, active-high. Every output and all state go to 0, except cmd_ready_out, which is 0 while reset_in is high and 1 in the first cycle after release. State returns to IDLE.
- States: IDLE, ISSUE, DRAIN.
- Handshake: a command is accepted at the rising edge where cmd_valid_in and cmd_ready_out are both 1 (call this edge T). cmd_ready_out = (state == IDLE).
  - Command fields are latched at T.
  - Command inputs are ignored whenever cmd_ready_out is 0.
- Normal command (opcode 0..4, len N > 0):
  - T+1 .. T+N: state ISSUE. rd_en_out=1, rd_addr_a_out = src_a+i, rd_addr_b_out = src_b+i, for i = 0..N-1. Addresses wrap modulo 2**ADDR_W.
  - T+2 .. T+N+1: alu_enable_out=1 and alu_opcode_out = latched opcode. alu_input1_out/alu_input2_out pass rd_data_a_in/rd_data_b_in through combinationally.
  - T+3 .. T+N+2: wr_en_out=1, wr_addr_out = dst+i (wraps), wr_data_out = alu_result_in.
  - After the last read the state is DRAIN until the last write completes.
  - T+N+3: state IDLE. done_out=1 for exactly one cycle, err_out=0. cmd_ready_out=1 in the same cycle, so back-to-back issue is legal.
  - Accept-to-done latency is N+3 cycles.
- When alu_enable_out is 0, alu_opcode_out and the operand outputs are don't-care. The opcode is held stable for the whole command.
- The pipeline runs as two-stage valid and destination-address shift registers (read→ALU, ALU→write). The sequencer never stalls: the register file and the ALU are always ready.
- len = 0: no reads, ALU enables or writes. done_out=1 at T+1, state stays IDLE.
- Opcode 5..7: illegal. No reads, ALU enables or writes. done_out=1 and err_out=1 at T+1.
- Arithmetic is entirely inside the ALU; the sequencer adds no width or sign handling. Results are DATA_W-bit truncated (overflow wraps). Compare opcodes write 1 or 0.
- Overlapping address ranges (dst inside src) are not hazard-checked. A read issued after a write to the same address returns the new value.
- busy_out = (state != IDLE).
- Reset mid-operation:
  - The in-flight command is dropped and the pipeline valids are cleared, so no wr_en_out occurs after reset asserts.
  - No done_out pulse is generated for the dropped command.
- Simultaneous cmd_valid_in and reset_in: reset wins and the command is not accepted.

Decomposition:
- Shared package tensor_core_pkg holds:
  - alu_opcode_t enum (ADD=0, SUBTRACT=1, MULTIPLY=2, EQUALS=3, GREATER_THAN=4), reused by the alu.
  - Constants OP_LAST_LEGAL=4 and DATA_W=8.
  - alu_cmd_t packed struct (opcode, src_a, src_b, dst, len).
- Sub-module: alu_issue_pipe, the 2-stage valid/write-address shift register with asynchronous clear. Everything else stays in the top module.

Test Plan:
1. ADD, src_a=0 [5,-3,127], src_b=4 [2,3,1], dst=8, len=3 → wr_en_out at T+3..T+5, addr 8,9,10, data 7,0,-128; done_out at T+6.
2. MULTIPLY, A [16,-4], B [16,3] → writes 0x00 and 0xF4 (-12); SUBTRACT, -128-1 → 127.
3. GREATER_THAN, A [-1,3], B [1,3] → writes 0,0; EQUALS on the same data → 0,1 (signed compare).
4. len=0 → done_out at T+1 with no rd_en_out/wr_en_out. Opcode 6, len=5 → done_out=err_out=1 at T+1 and no activity.
5. Address wrap and back-to-back: src_a=14, len=4 → reads 14,15,0,1. A second command held valid is accepted in the done_out cycle and its first rd_en_out follows the next cycle.
6. reset_in pulsed at T+2 of a len=4 command → all outputs 0 immediately, no wr_en_out afterwards, no done_out, cmd_ready_out=1 in the first cycle after release.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: types and constants shared by the tensor-core ALU and the
// sequencer that drives it.
//   alu_opcode_t   - ALU operation encoding (5..7 are unused / illegal)
//   alu_cmd_t      - one vector command as presented by instruction decode
//   opcode_is_legal- true for encodings the ALU implements
package tensor_core_pkg;

  localparam int DATA_W     = 8;
  localparam int CMD_ADDR_W = 4;
  localparam int CMD_LEN_W  = 5;

  localparam logic [2:0] OP_LAST_LEGAL = 3'd4;

  typedef enum logic [2:0] {
    ADD          = 3'd0,
    SUBTRACT     = 3'd1,
    MULTIPLY     = 3'd2,
    EQUALS       = 3'd3,
    GREATER_THAN = 3'd4
  } alu_opcode_t;

  // Opcode is kept as raw bits so an illegal encoding can still be carried.
  typedef struct packed {
    logic [2:0]            opcode;
    logic [CMD_ADDR_W-1:0] src_a;
    logic [CMD_ADDR_W-1:0] src_b;
    logic [CMD_ADDR_W-1:0] dst;
    logic [CMD_LEN_W-1:0]  len;
  } alu_cmd_t;

  function automatic logic opcode_is_legal(input logic [2:0] op);
    return (op <= OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: two-stage valid / write-address shift register that follows
// each issued read through the ALU and on to the register-file write.
//   clock_in, reset_in     - clock, asynchronous active-high clear
//   issue_valid/issue_addr - a read is being presented, with its result address
//   alu_valid              - operands of that read are at the ALU inputs
//   wr_valid/wr_addr       - ALU result is ready to be written at wr_addr
module alu_issue_pipe #(
  parameter int ADDR_W = 4
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              alu_valid,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr
);

  logic [ADDR_W-1:0] alu_addr_r;

  // Shift valid and destination address one stage per cycle; reset drops all.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      alu_valid  <= 1'b0;
      alu_addr_r <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
    end else begin
      alu_valid  <= issue_valid;
      alu_addr_r <= issue_addr;
      wr_valid   <= alu_valid;
      wr_addr    <= alu_addr_r;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one vector command at a time, streams operand
// pairs from the register file through the ALU and writes results back.
//   cmd_*           - command handshake and fields from instruction decode
//   rd_*            - synchronous register-file read port (data next cycle)
//   alu_*           - sole driver of the ALU inputs; alu_result_in is the
//                     ALU's registered output
//   wr_*            - register-file write port
//   busy/done/err   - status; done and err are one-cycle pulses
module alu_op_sequencer #(
  parameter int DATA_W = tensor_core_pkg::DATA_W,
  parameter int ADDR_W = tensor_core_pkg::CMD_ADDR_W,
  parameter int LEN_W  = tensor_core_pkg::CMD_LEN_W
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [2:0]        cmd_opcode_in,
  input  logic [ADDR_W-1:0] cmd_src_a_in,
  input  logic [ADDR_W-1:0] cmd_src_b_in,
  input  logic [ADDR_W-1:0] cmd_dst_in,
  input  logic [LEN_W-1:0]  cmd_len_in,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_a_out,
  output logic [ADDR_W-1:0] rd_addr_b_out,
  input  logic [DATA_W-1:0] rd_data_a_in,
  input  logic [DATA_W-1:0] rd_data_b_in,
  output logic              alu_enable_out,
  output logic [2:0]        alu_opcode_out,
  output logic [DATA_W-1:0] alu_input1_out,
  output logic [DATA_W-1:0] alu_input2_out,
  input  logic [DATA_W-1:0] alu_result_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  import tensor_core_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  alu_opcode_t       opcode_r;
  alu_cmd_t          cmd_s;
  logic              accept_s;
  logic [LEN_W-1:0]  remain_r;     // reads still to issue after the current one
  logic [ADDR_W-1:0] dst_ptr_r;    // result address paired with the current read
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_a_r;
  logic [ADDR_W-1:0] rd_addr_b_r;
  logic              done_r;
  logic              err_r;
  logic              alu_valid_s;
  logic              wr_valid_s;
  logic [ADDR_W-1:0] wr_addr_s;

  // Gather the incoming command fields into one struct.
  always_comb begin
    cmd_s        = '0;
    cmd_s.opcode = cmd_opcode_in;
    cmd_s.src_a  = cmd_src_a_in;
    cmd_s.src_b  = cmd_src_b_in;
    cmd_s.dst    = cmd_dst_in;
    cmd_s.len    = cmd_len_in;
  end

  // Ready is masked by reset so nothing is accepted while reset is held.
  assign cmd_ready_out = (state_r == ST_IDLE) & ~reset_in;
  assign accept_s      = cmd_valid_in & cmd_ready_out;

  // Command FSM: read issue, drain tracking and completion status.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_r     <= ST_IDLE;
      opcode_r    <= ADD;
      remain_r    <= '0;
      dst_ptr_r   <= '0;
      rd_en_r     <= 1'b0;
      rd_addr_a_r <= '0;
      rd_addr_b_r <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          rd_en_r <= 1'b0;
          if (accept_s) begin
            if (!opcode_is_legal(cmd_s.opcode)) begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else if (cmd_s.len == '0) begin
              done_r <= 1'b1;
            end else begin
              state_r     <= ST_ISSUE;
              opcode_r    <= alu_opcode_t'(cmd_s.opcode);
              rd_en_r     <= 1'b1;
              rd_addr_a_r <= cmd_s.src_a;
              rd_addr_b_r <= cmd_s.src_b;
              dst_ptr_r   <= cmd_s.dst;
              remain_r    <= cmd_s.len - LEN_W'(1);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (remain_r == '0) begin
            rd_en_r <= 1'b0;
            state_r <= ST_DRAIN;
          end else begin
            rd_en_r     <= 1'b1;
            rd_addr_a_r <= rd_addr_a_r + ADDR_W'(1);
            rd_addr_b_r <= rd_addr_b_r + ADDR_W'(1);
            dst_ptr_r   <= dst_ptr_r + ADDR_W'(1);
            remain_r    <= remain_r - LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          // Last write is on the port and nothing is left behind it.
          if (wr_valid_s && !alu_valid_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rd_en_r <= 1'b0;
        end
      endcase
    end
  end

  alu_issue_pipe #(
    .ADDR_W (ADDR_W)
  ) u_issue_pipe (
    .clock_in    (clock_in),
    .reset_in    (reset_in),
    .issue_valid (rd_en_r),
    .issue_addr  (dst_ptr_r),
    .alu_valid   (alu_valid_s),
    .wr_valid    (wr_valid_s),
    .wr_addr     (wr_addr_s)
  );

  assign rd_en_out      = rd_en_r;
  assign rd_addr_a_out  = rd_addr_a_r;
  assign rd_addr_b_out  = rd_addr_b_r;
  assign alu_enable_out = alu_valid_s;
  assign alu_opcode_out = opcode_r;
  // Pass-through data paths are zeroed when their stage is idle.
  assign alu_input1_out = alu_valid_s ? rd_data_a_in : '0;
  assign alu_input2_out = alu_valid_s ? rd_data_b_in : '0;
  assign wr_en_out      = wr_valid_s;
  assign wr_addr_out    = wr_addr_s;
  assign wr_data_out    = wr_valid_s ? alu_result_in : '0;
  assign busy_out       = (state_r != ST_IDLE);
  assign done_out       = done_r;
  assign err_out        = err_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [3:0] b;
  } rd_item_t;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_opcode = 3'd0;
  logic [3:0] cmd_src_a = 4'd0;
  logic [3:0] cmd_src_b = 4'd0;
  logic [3:0] cmd_dst = 4'd0;
  logic [4:0] cmd_len = 5'd0;
  logic       rd_en;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a = 8'd0, rd_data_b = 8'd0;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [7:0] alu_in1, alu_in2;
  logic [7:0] alu_res = 8'd0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done, err;

  logic [7:0] mem [0:15];
  logic       pl_en = 1'b0;
  logic [3:0] pl_addr = 4'd0;
  logic [7:0] pl_data = 8'd0;

  rd_item_t   rdq[$];
  wr_item_t   wrq[$];
  logic [7:0] exp_w [0:7];
  logic [2:0] cur_op = 3'd0;
  int         ncyc = 0;
  int         n0 = 0;
  int         nassert = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clock_in       (clk),
    .reset_in       (rst),
    .cmd_valid_in   (cmd_valid),
    .cmd_ready_out  (cmd_ready),
    .cmd_opcode_in  (cmd_opcode),
    .cmd_src_a_in   (cmd_src_a),
    .cmd_src_b_in   (cmd_src_b),
    .cmd_dst_in     (cmd_dst),
    .cmd_len_in     (cmd_len),
    .rd_en_out      (rd_en),
    .rd_addr_a_out  (rd_addr_a),
    .rd_addr_b_out  (rd_addr_b),
    .rd_data_a_in   (rd_data_a),
    .rd_data_b_in   (rd_data_b),
    .alu_enable_out (alu_en),
    .alu_opcode_out (alu_op),
    .alu_input1_out (alu_in1),
    .alu_input2_out (alu_in2),
    .alu_result_in  (alu_res),
    .wr_en_out      (wr_en),
    .wr_addr_out    (wr_addr),
    .wr_data_out    (wr_data),
    .busy_out       (busy),
    .done_out       (done),
    .err_out        (err)
  );

  // Register file: synchronous read, write port, plus a bench preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
  end

  // ALU with a registered result.
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_op)
        3'd0: alu_res <= alu_in1 + alu_in2;
        3'd1: alu_res <= alu_in1 - alu_in2;
        3'd2: alu_res <= alu_in1 * alu_in2;
        3'd3: alu_res <= (alu_in1 == alu_in2) ? 8'd1 : 8'd0;
        3'd4: alu_res <= ($signed(alu_in1) > $signed(alu_in2)) ? 8'd1 : 8'd0;
        default: alu_res <= 8'd0;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Monitor: pops expected reads/writes whenever the DUT presents one.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (rd_en) begin
      if (rdq.size() == 0) begin
        nassert++; nfail++;
        $display("FAIL unexpected_read: got addr_a %0d addr_b %0d expected no read (cycle %0d)",
                 rd_addr_a, rd_addr_b, ncyc);
      end else begin
        rd_item_t r;
        r = rdq.pop_front();
        check("rd_cycle", 64'(ncyc), 64'(r.cyc));
        check("rd_addr_a", 64'(rd_addr_a), 64'(r.a));
        check("rd_addr_b", 64'(rd_addr_b), 64'(r.b));
      end
    end
    if (alu_en) check("alu_opcode", 64'(alu_op), 64'(cur_op));
    if (wr_en) begin
      if (wrq.size() == 0) begin
        nassert++; nfail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write (cycle %0d)",
                 wr_addr, wr_data, ncyc);
      end else begin
        wr_item_t w;
        w = wrq.pop_front();
        check("wr_cycle", 64'(ncyc), 64'(w.cyc));
        check("wr_addr", 64'(wr_addr), 64'(w.addr));
        check("wr_data", 64'(wr_data), 64'(w.data));
      end
    end
  end

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive a command, wait for acceptance, queue expected reads and writes.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [4:0] len,
                       input int n_rd, input int n_wr);
    int budget;
    budget = 0;
    cmd_opcode = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_len = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    n0 = ncyc;
    cur_op = op;
    for (int i = 0; i < n_rd; i++)
      rdq.push_back('{cyc: n0 + 1 + i, a: a + 4'(i), b: b + 4'(i)});
    for (int i = 0; i < n_wr; i++)
      wrq.push_back('{cyc: n0 + 3 + i, addr: d + 4'(i), data: exp_w[i]});
    #1 cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for done; check latency, err, ready and drained queues.
  task automatic wait_done(input string name, input int exp_k, input logic exp_err);
    int   k;
    logic seen;
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk); #1;
      k = ncyc - n0;
      if (k == 1) check({name, "_busy"}, 64'(busy), 64'(exp_k > 1));
      if (done) seen = 1'b1;
    end
    check({name, "_done_latency"}, seen ? 64'(k) : 64'hFFFF, 64'(exp_k));
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_ready_at_done"}, 64'(cmd_ready), 64'd1);
    check({name, "_rdq_drained"}, 64'(rdq.size()), 64'd0);
    check({name, "_wrq_drained"}, 64'(wrq.size()), 64'd0);
  endtask

  initial begin
    logic seen_done;
    #2;
    check("reset_outputs_zero",
          {cmd_ready, rd_en, rd_addr_a, rd_addr_b, alu_en, alu_op, alu_in1, alu_in2,
           wr_en, wr_addr, wr_data, busy, done, err}, 64'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("ready_after_reset", 64'(cmd_ready), 64'd1);
    check("idle_after_reset", 64'(busy), 64'd0);

    // 1: ADD with signed overflow
    load(4'd0, 8'd5); load(4'd1, 8'hFD); load(4'd2, 8'h7F);
    load(4'd4, 8'd2); load(4'd5, 8'd3);  load(4'd6, 8'd1);
    exp_w[0] = 8'd7; exp_w[1] = 8'd0; exp_w[2] = 8'h80;
    issue(3'd0, 4'd0, 4'd4, 4'd8, 5'd3, 3, 3);
    wait_done("add", 6, 1'b0);

    // 2: MULTIPLY truncation, SUBTRACT wrap
    load(4'd0, 8'd16); load(4'd1, 8'hFC); load(4'd4, 8'd16); load(4'd5, 8'd3);
    exp_w[0] = 8'h00; exp_w[1] = 8'hF4;
    issue(3'd2, 4'd0, 4'd4, 4'd8, 5'd2, 2, 2);
    wait_done("mul", 5, 1'b0);
    load(4'd0, 8'h80); load(4'd4, 8'd1);
    exp_w[0] = 8'h7F;
    issue(3'd1, 4'd0, 4'd4, 4'd8, 5'd1, 1, 1);
    wait_done("sub", 4, 1'b0);

    // 3: signed compares
    load(4'd0, 8'hFF); load(4'd1, 8'd3); load(4'd4, 8'd1); load(4'd5, 8'd3);
    exp_w[0] = 8'd0; exp_w[1] = 8'd0;
    issue(3'd4, 4'd0, 4'd4, 4'd8, 5'd2, 2, 2);
    wait_done("gt", 5, 1'b0);
    exp_w[0] = 8'd0; exp_w[1] = 8'd1;
    issue(3'd3, 4'd0, 4'd4, 4'd8, 5'd2, 2, 2);
    wait_done("eq", 5, 1'b0);

    // 4: len 0 and illegal opcode
    issue(3'd0, 4'd0, 4'd4, 4'd8, 5'd0, 0, 0);
    wait_done("len0", 1, 1'b0);
    issue(3'd6, 4'd0, 4'd4, 4'd8, 5'd5, 0, 0);
    wait_done("illegal", 1, 1'b1);

    // 5: address wrap, then back-to-back command held valid while busy
    load(4'd14, 8'd1); load(4'd15, 8'd2); load(4'd0, 8'd3); load(4'd1, 8'd4);
    load(4'd10, 8'd10); load(4'd11, 8'd20); load(4'd12, 8'd30); load(4'd13, 8'd40);
    exp_w[0] = 8'd11; exp_w[1] = 8'd22; exp_w[2] = 8'd33; exp_w[3] = 8'd44;
    issue(3'd0, 4'd14, 4'd10, 4'd4, 5'd4, 4, 4);
    cmd_opcode = 3'd1; cmd_src_a = 4'd10; cmd_src_b = 4'd14; cmd_dst = 4'd12;
    cmd_len = 5'd2; cmd_valid = 1'b1;
    wait_done("wrap", 7, 1'b0);
    exp_w[0] = 8'd9; exp_w[1] = 8'd18;
    issue(3'd1, 4'd10, 4'd14, 4'd12, 5'd2, 2, 2);
    wait_done("b2b", 5, 1'b0);

    // 6: reset during a command
    issue(3'd0, 4'd0, 4'd4, 4'd8, 5'd4, 2, 0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreset_outputs_zero",
          {cmd_ready, rd_en, rd_addr_a, rd_addr_b, alu_en, alu_op, alu_in1, alu_in2,
           wr_en, wr_addr, wr_data, busy, done, err}, 64'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("midreset_ready_after_release", 64'(cmd_ready), 64'd1);
    check("midreset_idle", 64'(busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("midreset_no_done", 64'(seen_done), 64'd0);
    check("midreset_rdq_drained", 64'(rdq.size()), 64'd0);
    check("midreset_wrq_drained", 64'(wrq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
